cp0_regs: RTL and testbench
===========================

Name: cp0_regs

Overview:
- CP0 system-control register file. It answers the mtc0/mfc0/eret/exception requests raised by instruction decode.
- Sits in the WB stage and commits exceptions and eret there.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Drives EPC back to next-PC selection and raises the interrupt request to the pipeline.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (legal values 1 or 2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- mtc0  in  1  write CP0 register addr/sel with wdata (WB-stage valid already qualified).
- addr  in  5  CP0 register number (rd field).
- sel  in  3  select field; only sel==0 addresses a register.
- wdata  in  32  mtc0 data (rt value).
- rdata  out  32  mfc0 read data, combinational from addr/sel.
- exc_valid  in  1  exception commits this cycle.
- exc_code  in  5  ExcCode to record (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12).
- exc_bd  in  1  excepting instruction is in a delay slot.
- exc_pc  in  32  PC of the excepting instruction.
- badvaddr_wen  in  1  load BadVAddr (address errors); ignored unless exc_valid.
- exc_badvaddr  in  32  faulting address.
- eret  in  1  eret commits this cycle.
- ext_int  in  6  hardware interrupt lines, level-sensitive, synchronous to clk.
- epc  out  32  current EPC register.
- status_exl  out  1  Status.EXL.
- int_pending  out  1  an enabled interrupt is pending.

Behaviour:
- Register map (sel 0): 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other addr, or sel!=0, reads 0 and ignores writes.
- Status:
  - bit22 BEV reads 1 (read-only).
  - IM[15:8], EXL bit1 and IE bit0 are read/write.
  - All other bits read 0.
- Cause:
  - BD bit31 and TI bit30 are read-only.
  - IP[15:10] is hardware-driven.
  - IP[9:8] is software read/write.
  - ExcCode[6:2] is read-only.
  - All other bits read 0.
- Reset (async): BadVAddr=0, Count=0, Compare=0, Status=0x0040_0000, Cause=0, EPC=0, divider phase=0. Resulting outputs: rdata per map, epc=0, status_exl=0, int_pending=0.
- Count:
  - COUNT_DIV=2: a phase bit toggles each cycle; Count increments (mod 2^32, wraps to 0) on cycles where the phase is 1.
  - COUNT_DIV=1: Count increments every cycle.
  - An mtc0 to Count loads wdata, clears the phase, and suppresses that cycle's increment.
- Timer:
  - Each cycle, if Count==Compare (register values) and no mtc0 to Compare occurs, Cause.TI<=1.
  - An mtc0 to Compare loads Compare and clears TI in the same edge; the clear wins over the set.
- Cause.IP sampling: IP[15:10] registers {ext_int[5]|TI, ext_int[4:0]} every cycle, giving one cycle of latency.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]). It is combinational from registers.
- Exception (exc_valid=1):
  - If Status.EXL==0: EPC<=exc_bd ? exc_pc-4 : exc_pc, and Cause.BD<=exc_bd.
  - If Status.EXL==1: EPC and BD are unchanged.
  - Always: ExcCode<=exc_code and Status.EXL<=1.
  - If badvaddr_wen: BadVAddr<=exc_badvaddr.
- eret (exc_valid=0): Status.EXL<=0. All other state is unchanged.
- Same-cycle priority is exc_valid > eret > mtc0:
  - Under exc_valid, both eret and mtc0 are ignored.
  - Under eret, an mtc0 is ignored.
- Writes take effect at the next edge. rdata shows the pre-write value during the write cycle; there is no read-after-write bypass.
- Count and TI keep advancing during exceptions and eret.

Test Plan:
- Reset: read Status -> 0x0040_0000; Cause, EPC and Compare -> 0. After reset release, read Count on cycle 10 -> 5 (COUNT_DIV=2).
- mtc0 Status 0xFFFF_FFFF, then mfc0 -> 0x0040_FF03. mtc0 Cause 0xFFFF_FFFF, then mfc0 -> 0x0000_0300.
- Exception in a delay slot: exc_valid=1, exc_bd=1, exc_pc=0xBFC0_0104, exc_code=8 -> EPC=0xBFC0_0100, Cause=0x8000_0020, status_exl=1.
  - Second exception: exc_pc=0x80, exc_code=12 -> EPC unchanged, BD unchanged, ExcCode=12.
- Timer: mtc0 Compare=Count+4 with Status IM7=1, IE=1 -> TI sets and int_pending rises after the match plus 1 cycle; mtc0 Compare clears TI.
- Same cycle exc_valid=1 + eret=1 + mtc0 EPC=0x1234 -> EXL=1, EPC=exception value, not 0x1234. eret alone next -> EXL=0.
- Count wrap: mtc0 Count=0xFFFF_FFFF -> Count reads 0 after 2 cycles; ext_int[2]=1 with IM4=1, IE=1 -> int_pending=1 one cycle later.

Source files
------------

// File: rtl/cp0_regs.sv
`default_nettype none
// ============================================================================
// Module   : cp0_regs
// Purpose  : CP0 system-control register file (BadVAddr, Count, Compare,
//            Status, Cause, EPC). Commits mtc0, eret and exceptions in WB,
//            feeds EPC back to next-PC selection and raises the interrupt
//            request to the pipeline.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i            rising-edge clock
//   reset_i          asynchronous active-high reset
//   mtc0_i           write CP0 register addr_i/sel_i with wdata_i
//   addr_i, sel_i    CP0 register number / select (only sel 0 is mapped)
//   wdata_i          mtc0 write data
//   rdata_o          mfc0 read data, combinational from addr_i/sel_i
//   exc_valid_i      exception commits this cycle
//   exc_code_i       ExcCode to record
//   exc_bd_i         excepting instruction sits in a delay slot
//   exc_pc_i         PC of the excepting instruction
//   badvaddr_wen_i   load BadVAddr with exc_badvaddr_i (only with exc_valid_i)
//   exc_badvaddr_i   faulting address
//   eret_i           eret commits this cycle
//   ext_int_i        level-sensitive hardware interrupt lines
//   epc_o            current EPC
//   status_exl_o     Status.EXL
//   int_pending_o    an enabled interrupt is pending
// ============================================================================
module cp0_regs #(
  parameter int unsigned COUNT_DIV = 2  // Count prescale: 1 or 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mtc0_i,
  input  logic [4:0]  addr_i,
  input  logic [2:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic        exc_bd_i,
  input  logic [31:0] exc_pc_i,
  input  logic        badvaddr_wen_i,
  input  logic [31:0] exc_badvaddr_i,
  input  logic        eret_i,
  input  logic [5:0]  ext_int_i,
  output logic [31:0] epc_o,
  output logic        status_exl_o,
  output logic        int_pending_o
);

  // Register numbers (sel 0)
  localparam logic [4:0]  c_addr_badvaddr = 5'd8;
  localparam logic [4:0]  c_addr_count    = 5'd9;
  localparam logic [4:0]  c_addr_compare  = 5'd11;
  localparam logic [4:0]  c_addr_status   = 5'd12;
  localparam logic [4:0]  c_addr_cause    = 5'd13;
  localparam logic [4:0]  c_addr_epc      = 5'd14;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q,    count_d;
  logic        phase_q,    phase_d;
  logic [31:0] compare_q,  compare_d;
  logic [7:0]  im_q,       im_d;       // Status.IM[15:8]
  logic        exl_q,      exl_d;      // Status.EXL
  logic        ie_q,       ie_d;       // Status.IE
  logic        bd_q,       bd_d;       // Cause.BD
  logic        ti_q,       ti_d;       // Cause.TI
  logic [5:0]  ip_hw_q,    ip_hw_d;    // Cause.IP[15:10]
  logic [1:0]  ip_sw_q,    ip_sw_d;    // Cause.IP[9:8]
  logic [4:0]  exc_code_q, exc_code_d; // Cause.ExcCode
  logic [31:0] epc_q,      epc_d;

  // ---------------------------------------------------------------------------
  // Write decode: an exception masks eret and mtc0, an eret masks mtc0.
  // ---------------------------------------------------------------------------
  logic w_mtc0_ok;
  logic w_wr_badvaddr;
  logic w_wr_count;
  logic w_wr_compare;
  logic w_wr_status;
  logic w_wr_cause;
  logic w_wr_epc;
  logic w_eret_ok;
  logic w_count_tick;

  assign w_mtc0_ok     = mtc0_i & ~exc_valid_i & ~eret_i & (sel_i == 3'd0);
  assign w_wr_badvaddr = w_mtc0_ok & (addr_i == c_addr_badvaddr);
  assign w_wr_count    = w_mtc0_ok & (addr_i == c_addr_count);
  assign w_wr_compare  = w_mtc0_ok & (addr_i == c_addr_compare);
  assign w_wr_status   = w_mtc0_ok & (addr_i == c_addr_status);
  assign w_wr_cause    = w_mtc0_ok & (addr_i == c_addr_cause);
  assign w_wr_epc      = w_mtc0_ok & (addr_i == c_addr_epc);
  assign w_eret_ok     = eret_i & ~exc_valid_i;

  // With a divide-by-two prescaler Count advances on the cycles where the
  // phase bit is already set; with no prescaler it advances every cycle.
  assign w_count_tick  = (COUNT_DIV == 1) ? 1'b1 : phase_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    phase_d    = phase_q;
    compare_d  = compare_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    // Count / prescaler. A software load restarts the prescaler and
    // swallows the increment of the loading cycle.
    if (w_wr_count) begin
      count_d = wdata_i;
      phase_d = 1'b0;
    end else begin
      count_d = count_q + {31'd0, w_count_tick};
      phase_d = (COUNT_DIV == 1) ? 1'b0 : ~phase_q;
    end

    // Timer: writing Compare acknowledges the timer and beats a same-cycle match.
    if (w_wr_compare) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end

    if (exc_valid_i) begin
      // A nested exception (EXL already set) must not overwrite the
      // return point of the first one.
      if (!exl_q) begin
        epc_d = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        bd_d  = exc_bd_i;
      end
      exc_code_d = exc_code_i;
      exl_d      = 1'b1;
      if (badvaddr_wen_i) begin
        badvaddr_d = exc_badvaddr_i;
      end
    end else if (w_eret_ok) begin
      exl_d = 1'b0;
    end else begin
      if (w_wr_badvaddr) begin
        badvaddr_d = wdata_i;
      end
      if (w_wr_status) begin
        im_d  = wdata_i[15:8];
        exl_d = wdata_i[1];
        ie_d  = wdata_i[0];
      end
      if (w_wr_cause) begin
        ip_sw_d = wdata_i[9:8];
      end
      if (w_wr_epc) begin
        epc_d = wdata_i;
      end
    end
  end

  // Hardware IP bits are a plain one-cycle sample; the timer shares line 5.
  assign ip_hw_d = {ext_int_i[5] | ti_q, ext_int_i[4:0]};

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      phase_q    <= 1'b0;
      compare_q  <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      compare_q  <= compare_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (no bypass: shows register contents before any pending write)
  // ---------------------------------------------------------------------------
  logic [31:0] w_status;
  logic [31:0] w_cause;

  // BEV (bit 22) is hard-wired to 1.
  assign w_status = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign w_cause  = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};

  always_comb begin
    rdata_o = 32'd0;
    if (sel_i == 3'd0) begin
      case (addr_i)
        c_addr_badvaddr: rdata_o = badvaddr_q;
        c_addr_count:    rdata_o = count_q;
        c_addr_compare:  rdata_o = compare_q;
        c_addr_status:   rdata_o = w_status;
        c_addr_cause:    rdata_o = w_cause;
        c_addr_epc:      rdata_o = epc_q;
        default:         rdata_o = 32'd0;
      endcase
    end
  end

  assign epc_o         = epc_q;
  assign status_exl_o  = exl_q;
  assign int_pending_o = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

endmodule
`default_nettype wire

// File: tb/tb_cp0_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_regs
// Purpose  : Self-checking bench for cp0_regs. A register-level model
//            tracks architectural CP0 state and is compared against the DUT
//            every cycle; directed steps add hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_regs;

  localparam int unsigned DIV = 2;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        mtc0_i = 1'b0;
  logic [4:0]  addr_i = 5'd0;
  logic [2:0]  sel_i = 3'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic        exc_valid_i = 1'b0;
  logic [4:0]  exc_code_i = 5'd0;
  logic        exc_bd_i = 1'b0;
  logic [31:0] exc_pc_i = 32'd0;
  logic        badvaddr_wen_i = 1'b0;
  logic [31:0] exc_badvaddr_i = 32'd0;
  logic        eret_i = 1'b0;
  logic [5:0]  ext_int_i = 6'd0;
  logic [31:0] epc_o;
  logic        status_exl_o;
  logic        int_pending_o;

  cp0_regs #(.COUNT_DIV(DIV)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .mtc0_i         (mtc0_i),
    .addr_i         (addr_i),
    .sel_i          (sel_i),
    .wdata_i        (wdata_i),
    .rdata_o        (rdata_o),
    .exc_valid_i    (exc_valid_i),
    .exc_code_i     (exc_code_i),
    .exc_bd_i       (exc_bd_i),
    .exc_pc_i       (exc_pc_i),
    .badvaddr_wen_i (badvaddr_wen_i),
    .exc_badvaddr_i (exc_badvaddr_i),
    .eret_i         (eret_i),
    .ext_int_i      (ext_int_i),
    .epc_o          (epc_o),
    .status_exl_o   (status_exl_o),
    .int_pending_o  (int_pending_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Architectural model. Count is kept as "value at last load" plus elapsed
  // cycles divided by the prescale, instead of a phase bit.
  // ---------------------------------------------------------------------------
  logic [31:0] m_badv, m_base, m_cmp, m_epc;
  int unsigned m_ticks;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_ticks / DIV);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    logic [31:0] v;
    v = 32'd0;
    if (s == 3'd0) begin
      case (a)
        5'd8:  v = m_badv;
        5'd9:  v = m_count();
        5'd11: v = m_cmp;
        5'd12: v = 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
        5'd13: v = (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_iphw) << 10)
                 | (32'(m_ipsw) << 8) | (32'(m_exc) << 2);
        5'd14: v = m_epc;
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  function automatic logic m_intp();
    return m_ie && !m_exl && (({m_iphw, m_ipsw} & m_im) != 8'd0);
  endfunction

  task automatic model_reset();
    m_badv = 0; m_base = 0; m_ticks = 0; m_cmp = 0; m_epc = 0;
    m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
    m_iphw = 0; m_ipsw = 0; m_exc = 0;
  endtask

  task automatic model_step();
    logic [31:0] old_cnt;
    logic [31:0] old_cmp;
    logic        old_ti;
    logic        wr;
    old_cnt = m_count();
    old_cmp = m_cmp;
    old_ti  = m_ti;
    wr = mtc0_i && !exc_valid_i && !eret_i && (sel_i == 3'd0);

    m_ticks = m_ticks + 1;
    if (wr && addr_i == 5'd9) begin
      m_base  = wdata_i;
      m_ticks = 0;
    end
    if (wr && addr_i == 5'd11) begin
      m_cmp = wdata_i;
      m_ti  = 1'b0;
    end else if (old_cnt == old_cmp) begin
      m_ti = 1'b1;
    end
    m_iphw = {ext_int_i[5] | old_ti, ext_int_i[4:0]};

    if (exc_valid_i) begin
      if (!m_exl) begin
        m_epc = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
        m_bd  = exc_bd_i;
      end
      m_exc = exc_code_i;
      m_exl = 1'b1;
      if (badvaddr_wen_i) m_badv = exc_badvaddr_i;
    end else if (eret_i) begin
      m_exl = 1'b0;
    end else if (wr) begin
      case (addr_i)
        5'd8:  m_badv = wdata_i;
        5'd12: begin m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0]; end
        5'd13: m_ipsw = wdata_i[9:8];
        5'd14: m_epc = wdata_i;
        default: ;
      endcase
    end
  endtask

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) model_reset();
    else         model_step();
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk_i) begin
    #1;
    if (!reset_i) begin
      chk("rdata", rdata_o, m_read(addr_i, sel_i));
      chk("epc", epc_o, m_epc);
      chk("status_exl", 32'(status_exl_o), 32'(m_exl));
      chk("int_pending", 32'(int_pending_o), 32'(m_intp()));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    mtc0_i = 0; exc_valid_i = 0; eret_i = 0; badvaddr_wen_i = 0;
    sel_i = 0; exc_bd_i = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle();
    mtc0_i = 1; addr_i = a; wdata_i = d;
    tick();
    idle();
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    addr_i = a;
    #2;
    chk(name, rdata_o, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit hit;
    #1 reset_i = 1;
    @(negedge clk_i);
    addr_i = 5'd12; #1 chk("rst_status", rdata_o, 32'h0040_0000);
    addr_i = 5'd13; #1 chk("rst_cause", rdata_o, 32'h0);
    addr_i = 5'd14; #1 chk("rst_epc_reg", rdata_o, 32'h0);
    addr_i = 5'd11; #1 chk("rst_compare", rdata_o, 32'h0);
    chk("rst_intp", 32'(int_pending_o), 32'h0);

    @(negedge clk_i);
    reset_i = 0;
    addr_i  = 5'd9;
    repeat (10) tick();
    rd_chk("count_cycle10", 5'd9, 32'd5);

    // Move Compare away so the reset-time match stops driving TI/IP7.
    wr(5'd11, 32'h1000_0000);
    tick();
    wr(5'd12, 32'hFFFF_FFFF);
    rd_chk("status_mask", 5'd12, 32'h0040_FF03);
    wr(5'd13, 32'hFFFF_FFFF);
    rd_chk("cause_mask", 5'd13, 32'h0000_0300);
    wr(5'd12, 32'h0);
    wr(5'd13, 32'h0);

    // Exception in a delay slot, with BadVAddr capture.
    exc_valid_i = 1; exc_bd_i = 1; exc_pc_i = 32'hBFC0_0104; exc_code_i = 5'd8;
    badvaddr_wen_i = 1; exc_badvaddr_i = 32'hDEAD_BEE0;
    tick();
    idle();
    rd_chk("exc1_cause", 5'd13, 32'h8000_0020);
    chk("exc1_epc", epc_o, 32'hBFC0_0100);
    chk("exc1_exl", 32'(status_exl_o), 32'h1);
    rd_chk("exc1_badvaddr", 5'd8, 32'hDEAD_BEE0);

    // Nested exception: EPC/BD frozen, ExcCode updated.
    exc_valid_i = 1; exc_bd_i = 0; exc_pc_i = 32'h0000_0080; exc_code_i = 5'd12;
    tick();
    idle();
    rd_chk("exc2_cause", 5'd13, 32'h8000_0030);
    chk("exc2_epc", epc_o, 32'hBFC0_0100);

    eret_i = 1;
    tick();
    idle();
    chk("eret1_exl", 32'(status_exl_o), 32'h0);

    // exc + eret + mtc0 EPC in the same cycle: exception wins.
    exc_valid_i = 1; eret_i = 1; mtc0_i = 1; addr_i = 5'd14; wdata_i = 32'h0000_1234;
    exc_pc_i = 32'h0000_2000; exc_code_i = 5'd9;
    tick();
    idle();
    chk("prio_epc", epc_o, 32'h0000_2000);
    chk("prio_exl", 32'(status_exl_o), 32'h1);
    eret_i = 1;
    tick();
    idle();
    chk("eret2_exl", 32'(status_exl_o), 32'h0);
    // eret masks a same-cycle mtc0
    eret_i = 1; mtc0_i = 1; addr_i = 5'd14; wdata_i = 32'h0000_5555;
    tick();
    idle();
    chk("eret_mtc0_epc", epc_o, 32'h0000_2000);

    // Timer interrupt through IM7.
    wr(5'd12, 32'h0000_8001);
    wr(5'd11, m_count() + 32'd4);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (int_pending_o) begin
        hit = 1;
        break;
      end
    end
    chk("timer_irq", 32'(hit), 32'h1);
    wr(5'd11, m_count() + 32'd1000);
    rd_chk("ti_cleared", 5'd13, (m_read(5'd13, 3'd0) & 32'hBFFF_FFFF));
    chk("ti_bit", 32'(rdata_o[30]), 32'h0);
    tick();
    chk("timer_irq_drop", 32'(int_pending_o), 32'h0);

    // Count wrap.
    wr(5'd9, 32'hFFFF_FFFF);
    rd_chk("wrap0", 5'd9, 32'hFFFF_FFFF);
    tick();
    rd_chk("wrap1", 5'd9, 32'hFFFF_FFFF);
    tick();
    rd_chk("wrap2", 5'd9, 32'h0000_0000);

    // External interrupt line 2 through IM4.
    wr(5'd12, 32'h0000_1001);
    ext_int_i = 6'b000100;
    #2 chk("ext_before", 32'(int_pending_o), 32'h0);
    tick();
    #2 chk("ext_after", 32'(int_pending_o), 32'h1);
    ext_int_i = 6'd0;
    tick();
    #2 chk("ext_drop", 32'(int_pending_o), 32'h0);

    // sel != 0 and unmapped registers.
    idle();
    mtc0_i = 1; addr_i = 5'd14; sel_i = 3'd1; wdata_i = 32'hCAFE_F00D;
    tick();
    idle();
    sel_i = 3'd1;
    rd_chk("sel1_read", 5'd14, 32'h0);
    sel_i = 3'd0;
    chk("sel1_nowrite", epc_o, 32'h0000_2000);
    rd_chk("unmapped", 5'd10, 32'h0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
